// File: rtl/clk_gate_pkg.sv
// Shared types and default constants for the clock-gating controller.
package clk_gate_pkg;

  // Per-channel gate FSM states
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    DRAIN = 2'd2
  } ch_state_e;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DRAIN_CYCLES = 3;

  // Drain counter width, large enough for DRAIN_CYCLES up to 255
  localparam int CNT_W = 8;

endpackage

// File: rtl/clk_gate_ch.sv
// One gated clock channel: enable synchroniser, OFF/ON/DRAIN FSM with drain
// counter, registered gate enable, and a low-transparent latch + AND gate.
module clk_gate_ch
  import clk_gate_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic en_i,
  input  logic force_on_i,
  output logic gclk_o,
  output logic ack_o,
  output logic gate_en_next_o
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  logic             en_sync;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_en_q, gate_en_d;
  logic             gate_latch;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign en_sync = en_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw request through the synchroniser chain
      always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= en_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign en_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Next state and drain count; a re-request in DRAIN wins over expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (en_sync) state_d = ON;
      end
      ON: begin
        if (!en_sync) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = OFF;
          end else begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        if (en_sync) begin
          state_d = ON;
        end else if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  assign gate_en_d = (state_d != OFF);

  // State, counter and gate-enable registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      gate_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gate_en_q <= gate_en_d;
    end
  end

  // Gate latch: only follows while clk_i is low so gclk_o never sees a runt
  always_latch begin
    if (!arst_ni) begin
      gate_latch <= 1'b0;
    end else if (!clk_i) begin
      gate_latch <= gate_en_q | force_on_i;
    end
  end

  assign gclk_o         = clk_i & gate_latch;
  assign ack_o          = gate_en_q;
  assign gate_en_next_o = gate_en_d;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: NUM_CH independent gate channels
// plus a registered count of channels whose gate enable is asserted.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NUM_CH-1:0]             en_i,
  input  logic                          force_on_i,
  output logic [NUM_CH-1:0]             gclk_o,
  output logic [NUM_CH-1:0]             ack_o,
  output logic [$clog2(NUM_CH+1)-1:0]   active_cnt_o
);

  localparam int ACT_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] gate_en_next;

  function automatic logic [ACT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [ACT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + ACT_W'(v[i]);
    end
    return n;
  endfunction

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clk_gate_ch #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DRAIN_CYCLES (DRAIN_CYCLES)
      ) u_ch (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .en_i           (en_i[c]),
        .force_on_i     (force_on_i),
        .gclk_o         (gclk_o[c]),
        .ack_o          (ack_o[c]),
        .gate_en_next_o (gate_en_next[c])
      );
    end
  endgenerate

  // Count from the next-state enables so the count lands with ack_o
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      active_cnt_o <= '0;
    end else begin
      active_cnt_o <= popcount(gate_en_next);
    end
  end

endmodule
